// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
package serial_add_pkg;

    // Controller states of the digit-serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // Number of digit steps needed to cover the full operand width
    function automatic int unsigned ndig(input int unsigned width, input int unsigned digit);
        return width / digit;
    endfunction

    // Counter width for n steps; a single-step add still needs a 1-bit counter
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_addn_add_digit.sv
// DIGIT-wide ripple-carry cell; also exposes the carry into its top bit for overflow.
module add_digit #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = c_in;

    // Chain of full adders, carry rippling from bit 0 upward
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        assign s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
        assign c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
    end

    assign c_out = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/serial_addn.sv
// Digit-serial WIDTH-bit adder: DIGIT bits per clock with valid/ready on both sides.
module serial_addn
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int unsigned NDIG = ndig(WIDTH, DIGIT);
    localparam int unsigned CW   = cnt_w(NDIG);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] s_dig;
    logic             c_dig;
    logic             c_msb_dig;
    logic             accept;
    logic             last_dig;

    add_digit #(
        .DIGIT (DIGIT)
    ) u_add_digit (
        .a_d   (a_q[DIGIT-1:0]),
        .b_d   (b_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .s_d   (s_dig),
        .c_out (c_dig),
        .c_msb (c_msb_dig)
    );

    assign accept   = in_valid && in_ready;
    assign last_dig = (cnt_q == CW'(NDIG - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a HOLD handshake with fresh operands goes straight back to RUN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (last_dig) state_d = HOLD;
            HOLD: if (out_ready) state_d = in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: in_ready = 1'b1;
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    // Datapath next values: load on accept, one digit step per RUN cycle
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = ci;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            sum_d   = (sum_q >> DIGIT) | (WIDTH'(s_dig) << (WIDTH - DIGIT));
            carry_d = c_dig;
            cnt_d   = cnt_q + CW'(1);
            if (last_dig) begin
                ovf_d = c_msb_dig ^ c_dig;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    // The running carry after the final digit is the carry out of the MSB
    assign sum = sum_q;
    assign co  = carry_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_serial_addn.sv
// Scoreboard bench for serial_addn: a 16/4 instance and an 8/1 instance, exercised one at a time.
module tb_serial_addn;

    typedef struct {
        int          inst;
        int          acc;
        logic [17:0] res;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a_drv, b_drv;
    logic        ci_drv;
    logic [1:0]  in_valid, out_ready;
    logic        ir0, ir1, ov0, ov1, co0, co1, of0, of1;
    logic [1:0]  in_ready, out_valid, co, ovf;
    logic [15:0] sum16;
    logic [7:0]  sum8;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          rand_bp = 1'b0;
    bit          seen[2];
    logic [17:0] held[2];

    assign in_ready  = {ir1, ir0};
    assign out_valid = {ov1, ov0};
    assign co        = {co1, co0};
    assign ovf       = {of1, of0};

    always #5 clk = ~clk;

    serial_addn #(.WIDTH(16), .DIGIT(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0),
        .a(a_drv), .b(b_drv), .ci(ci_drv), .out_valid(ov0), .out_ready(out_ready[0]),
        .sum(sum16), .co(co0), .ovf(of0)
    );

    serial_addn #(.WIDTH(8), .DIGIT(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1),
        .a(a_drv[7:0]), .b(b_drv[7:0]), .ci(ci_drv), .out_valid(ov1), .out_ready(out_ready[1]),
        .sum(sum8), .co(co1), .ovf(of1)
    );

    function automatic int ndig_of(input int inst);
        return (inst == 0) ? 4 : 8;
    endfunction

    // Reference: plain integer addition, signed overflow from operand/result signs
    function automatic logic [17:0] model(input int inst, input logic [15:0] a, input logic [15:0] b, input logic ci);
        int unsigned       w;
        longint unsigned   m, aa, bb, full, s;
        logic              c, o, sa, sbit, ss;
        w    = (inst == 0) ? 16 : 8;
        m    = (64'd1 << w) - 1;
        aa   = longint'(a) & m;
        bb   = longint'(b) & m;
        full = aa + bb + longint'(ci);
        s    = full & m;
        c    = full[w];
        sa   = aa[w-1];
        sbit = bb[w-1];
        ss   = s[w-1];
        o    = (sa == sbit) && (ss != sa);
        return {o, c, s[15:0]};
    endfunction

    function automatic logic [17:0] cur_out(input int inst);
        return (inst == 0) ? {ovf[0], co[0], sum16} : {ovf[1], co[1], 8'h00, sum8};
    endfunction

    function automatic logic [15:0] pick();
        int r;
        r = $urandom_range(0, 7);
        case (r)
            0: return 16'hFFFF;
            1: return 16'h8000;
            2: return 16'h7FFF;
            3: return 16'h0000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present operands (called just after a posedge); push expectation on the accepting edge
    task automatic send(input int inst, input logic [15:0] a, input logic [15:0] b, input logic ci);
        bit ok;
        ok = 1'b0;
        a_drv = a;
        b_drv = b;
        ci_drv = ci;
        in_valid[inst] = 1'b1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (in_ready[inst]) begin
                sb.push_back('{inst: inst, acc: cyc + 1, res: model(inst, a, b, ci)});
                ok = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid[inst] = 1'b0;
        if (!ok) check("accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_drain();
        int k;
        for (k = 0; k < 400 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready[0] = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: latency on first valid cycle, stability while held, compare on handshake
    initial begin
        seen[0] = 1'b0;
        seen[1] = 1'b0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst || !out_valid[i]) begin
                    seen[i] = 1'b0;
                end else begin
                    check("hold_in_ready", 32'(in_ready[i]), 32'(out_ready[i]));
                    if (!seen[i]) begin
                        check("pending_result", 32'(sb.size() != 0 && sb[0].inst == i), 32'd1);
                        if (sb.size() != 0 && sb[0].inst == i)
                            check("latency", 32'(cyc), 32'(sb[0].acc + ndig_of(i)));
                        seen[i] = 1'b1;
                        held[i] = cur_out(i);
                    end else begin
                        check("hold_stable", 32'(cur_out(i)), 32'(held[i]));
                    end
                    if (out_ready[i]) begin
                        if (sb.size() != 0 && sb[0].inst == i) begin
                            check("result", 32'(cur_out(i)), 32'(sb[0].res));
                            void'(sb.pop_front());
                        end
                        seen[i] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        in_valid = 2'b00;
        out_ready = 2'b11;
        a_drv = '0;
        b_drv = '0;
        ci_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset values on both instances
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", 32'(in_ready[i]), 32'd1);
            check("rst_out_valid", 32'(out_valid[i]), 32'd0);
            check("rst_outputs", 32'(cur_out(i)), 32'd0);
        end
        @(posedge clk);
        #1;

        // Directed adds on the 16/4 instance
        send(0, 16'h1234, 16'h4321, 1'b0);
        wait_drain();
        send(0, 16'hFFFF, 16'h0000, 1'b1);
        wait_drain();
        send(0, 16'h7FFF, 16'h0001, 1'b0);
        wait_drain();

        // Backpressure in HOLD, then release together with a new accept
        out_ready[0] = 1'b0;
        send(0, 16'hA5A5, 16'h5A5A, 1'b1);
        for (int k = 0; k < 50 && !out_valid[0]; k++) @(negedge clk);
        check("bp_valid_seen", 32'(out_valid[0]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        send(0, 16'h0001, 16'h0002, 1'b0);
        wait_drain();

        // Asynchronous reset two digits into a RUN
        send(0, 16'hBEEF, 16'h1111, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrun_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrun_sum", 32'(sum16), 32'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("post_rst_out_valid", 32'(out_valid[0]), 32'd0);
        repeat (12) @(posedge clk);
        #1;

        // Random traffic with random backpressure on the 16/4 instance
        rand_bp = 1'b1;
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(0, pick(), pick(), 1'($urandom_range(0, 1)));
        end
        rand_bp = 1'b0;
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
        wait_drain();

        // 8/1 instance: directed corner then random back-to-back
        send(1, 16'h0080, 16'h0080, 1'b0);
        wait_drain();
        for (int t = 0; t < 12; t++) begin
            send(1, pick(), pick(), 1'($urandom_range(0, 1)));
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
